// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, constants and helpers for the game board draw logic
//
// Contents:
//   draw_state_t  channel FSM states (IDLE, WAIT)
//   LFSR_W        width of the shared Galois LFSR
//   LFSR_TAPS     Galois feedback mask applied on a right shift with lsb=1
//   DEF_*         default value-range parameters (a card value 1..10 in 5 bits)
//   rotr          rotate right of an LFSR word; gives each channel its own view of the LFSR
package game_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } draw_state_t;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_MIN   = 1;
    localparam int DEF_MAX   = 10;

    function automatic logic [LFSR_W-1:0] rotr(input logic [LFSR_W-1:0] v, input int sh);
        int s;
        s = sh % LFSR_W;
        // A shift by LFSR_W yields zero, so s == 0 returns v unchanged.
        rotr = (v >> s) | (v << (LFSR_W - s));
    endfunction

endpackage

// File: rtl/draw_channel.sv
// rtl/draw_channel.sv - one key-driven draw channel: key synchroniser, edge detect, draw FSM
//
// Ports:
//   clock, reset_n  system clock, synchronous active-low reset
//   load_n          raw active-low key, asynchronous to clock
//   mode            0 = take the counter value, 1 = take the LFSR candidate
//   count           shared counter value (always in range)
//   cand, cand_ok   this channel's LFSR candidate and its in-range flag
//   q               captured value, held between draws
//   valid           one-cycle pulse when q updates
//   busy            high while waiting for an in-range LFSR candidate
module draw_channel
    import game_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_TRIES = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] cand,
    input  logic             cand_ok,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    logic          sync_1;
    logic          sync_2;
    logic          sync_3;
    logic          evt;
    draw_state_t   state;
    logic [TW-1:0] tries;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sync_3 <= 1'b1;
            evt    <= 1'b0;
            state  <= IDLE;
            tries  <= '0;
            q      <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // sync_1/sync_2 resolve metastability; sync_3 is the previous
            // settled level, so evt is a registered falling-edge pulse.
            sync_1 <= load_n;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            evt    <= sync_3 & ~sync_2;
            valid  <= 1'b0;

            case (state)
                IDLE: begin
                    // An edge landing right after a WAIT completion is dropped
                    // so that valid never stays high two cycles in a row.
                    if (evt && !valid) begin
                        if (!mode) begin
                            q     <= count;
                            valid <= 1'b1;
                        end else if (cand_ok) begin
                            q     <= cand;
                            valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            tries <= TW'(1);
                            busy  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // mode and evt are ignored here; the draw finishes under
                    // LFSR rules and the tries bound guarantees termination.
                    if (cand_ok) begin
                        q     <= cand;
                        valid <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tries == TW'(MAX_TRIES)) begin
                        q     <= count;
                        valid <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/random_draw_unit.sv
// rtl/random_draw_unit.sv - multi-channel random draw source with shared counter and LFSR
//
// Ports:
//   clock, reset_n  system clock, synchronous active-low reset
//   enable          1 = counter and LFSR advance each cycle, 0 = hold
//   mode            0 = counter sweep draws, 1 = LFSR draws with range rejection
//   load_n          raw active-low keys, one per channel
//   q               captured values, channel c at [c*WIDTH +: WIDTH]
//   valid           per-channel one-cycle pulse when its q updates
//   busy            per-channel flag, high while the channel waits for a usable candidate
module random_draw_unit
    import game_pkg::*;
#(
    parameter int              NUM_CH    = 3,
    parameter int              WIDTH     = DEF_WIDTH,
    parameter int              MIN_VAL   = DEF_MIN,
    parameter int              MAX_VAL   = DEF_MAX,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int              MAX_TRIES = 15
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [NUM_CH-1:0]       load_n,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       valid,
    output logic [NUM_CH-1:0]       busy
);

    localparam int SPAN = MAX_VAL - MIN_VAL;

    if (!(MIN_VAL >= 0 && MIN_VAL <= MAX_VAL && MAX_VAL < (2 ** WIDTH) &&
          LFSR_SEED != '0 && MAX_TRIES >= 1 && WIDTH <= LFSR_W && NUM_CH >= 1)) begin : g_param_error
        $error("random_draw_unit: illegal parameter set");
    end

    logic [WIDTH-1:0]  count;
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= WIDTH'(MIN_VAL);
        end else if (enable) begin
            count <= (count == WIDTH'(MAX_VAL)) ? WIDTH'(MIN_VAL) : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr == '0) begin
            // Lock-up state is unreachable from a non-zero seed; recover anyway.
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] raw;
        logic [WIDTH-1:0] cand;
        logic             cand_ok;

        // Each channel sees the LFSR rotated by 5*c so simultaneous draws differ.
        assign raw     = WIDTH'(rotr(lfsr, 5 * c));
        assign cand_ok = (raw <= WIDTH'(SPAN));
        assign cand    = WIDTH'(MIN_VAL) + raw;

        draw_channel #(
            .WIDTH     (WIDTH),
            .MAX_TRIES (MAX_TRIES)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .load_n  (load_n[c]),
            .mode    (mode),
            .count   (count),
            .cand    (cand),
            .cand_ok (cand_ok),
            .q       (q[c*WIDTH +: WIDTH]),
            .valid   (valid[c]),
            .busy    (busy[c])
        );
    end

endmodule
